branch_resolve_stage: RTL and testbench

- Execute-stage consumer of the comparison-op decoder output. It registers each instruction's compop and operands and evaluates the comparison.
- For SLT/SLTI/SLTU/SLTIU it produces the 0/1 result. For conditional branches it resolves taken/not-taken, computes the target, and flags mispredictions as a fetch redirect.
- Valid/ready pipelined stage with a one-entry skid buffer, so upstream ready never depends combinationally on downstream ready.

---
 rtl/branch_resolve_stage_if.sv | 45 ++++
 rtl/branch_resolve_stage.sv | 133 +++++++++++++
 tb/tb_branch_resolve_stage.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_stage_if.sv
// Comparison-op encoding shared with the decoder, plus the handshake/data bundle
// between the decoder, the branch resolve stage and its downstream consumer.
package branch_resolve_pkg;
   typedef enum logic [2:0] {
      compop_nop = 3'd0,
      compop_eq  = 3'd1,
      compop_ne  = 3'd2,
      compop_lts = 3'd3,
      compop_ltu = 3'd4,
      compop_ges = 3'd5,
      compop_geu = 3'd6
   } rv32_compop;
endpackage

interface branch_resolve_stage_if #(parameter int XLEN = 32);
   logic                          i_valid;
   logic                          o_ready;
   branch_resolve_pkg::rv32_compop i_compop;
   logic                          i_is_branch;
   logic [XLEN-1:0]               i_rs1;
   logic [XLEN-1:0]               i_rs2;
   logic [XLEN-1:0]               i_pc;
   logic [XLEN-1:0]               i_imm;
   logic                          i_pred_taken;
   logic                          o_valid;
   logic                          i_ready;
   logic [XLEN-1:0]               o_result;
   logic                          o_taken;
   logic [XLEN-1:0]               o_target;
   logic                          o_redirect;
   logic                          o_misaligned;
   logic                          i_flush;

   modport master (
      output i_valid, i_compop, i_is_branch, i_rs1, i_rs2, i_pc, i_imm,
             i_pred_taken, i_ready, i_flush,
      input  o_ready, o_valid, o_result, o_taken, o_target, o_redirect, o_misaligned
   );

   modport slave (
      input  i_valid, i_compop, i_is_branch, i_rs1, i_rs2, i_pc, i_imm,
             i_pred_taken, i_ready, i_flush,
      output o_ready, o_valid, o_result, o_taken, o_target, o_redirect, o_misaligned
   );
endinterface

// File: rtl/branch_resolve_stage.sv
// Execute-stage branch/SLT resolver: registers decoded operands behind a one-entry
// skid buffer, evaluates the comparison and raises fetch redirects on mispredicts.
module branch_resolve_stage
   import branch_resolve_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   branch_resolve_stage_if.slave bus,
   output logic [CNT_W-1:0]      o_mispredict_cnt
);

   typedef struct packed {
      rv32_compop      compop;
      logic            is_branch;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic            pred_taken;
   } entry_t;

   entry_t            out_reg, out_next;
   entry_t            skid_reg, skid_next;
   logic              out_valid_reg, out_valid_next;
   logic              skid_valid_reg, skid_valid_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;

   entry_t            in_entry;
   logic              in_fire;
   logic              out_fire;
   logic              out_free;

   logic              cond;
   logic              taken;
   logic [XLEN-1:0]   target;
   logic              misaligned;
   logic              redirect;

   assign in_entry = '{compop:     bus.i_compop,
                       is_branch:  bus.i_is_branch,
                       rs1:        bus.i_rs1,
                       rs2:        bus.i_rs2,
                       pc:         bus.i_pc,
                       imm:        bus.i_imm,
                       pred_taken: bus.i_pred_taken};

   // Ready comes straight from the skid flag so upstream never sees i_ready combinationally.
   assign bus.o_ready = !skid_valid_reg;
   assign in_fire     = bus.i_valid && !skid_valid_reg;
   assign out_fire    = out_valid_reg && bus.i_ready;
   assign out_free    = !out_valid_reg || bus.i_ready;

   always_comb begin
      out_next        = out_reg;
      skid_next       = skid_reg;
      out_valid_next  = out_valid_reg;
      skid_valid_next = skid_valid_reg;
      if (bus.i_flush) begin
         out_valid_next  = 1'b0;
         skid_valid_next = 1'b0;
      end else if (out_free) begin
         if (skid_valid_reg) begin
            out_next        = skid_reg;
            out_valid_next  = 1'b1;
            skid_valid_next = 1'b0;
         end else begin
            out_valid_next = in_fire;
            if (in_fire) begin
               out_next = in_entry;
            end
         end
      end else if (in_fire) begin
         skid_next       = in_entry;
         skid_valid_next = 1'b1;
      end
   end

   always_comb begin
      cond = 1'b0;
      case (out_reg.compop)
         compop_eq:  cond = (out_reg.rs1 == out_reg.rs2);
         compop_ne:  cond = (out_reg.rs1 != out_reg.rs2);
         compop_lts: cond = ($signed(out_reg.rs1) <  $signed(out_reg.rs2));
         compop_ltu: cond = (out_reg.rs1 <  out_reg.rs2);
         compop_ges: cond = ($signed(out_reg.rs1) >= $signed(out_reg.rs2));
         compop_geu: cond = (out_reg.rs1 >= out_reg.rs2);
         default:    cond = 1'b0;
      endcase
   end

   assign taken      = out_reg.is_branch && cond;
   assign target     = taken ? (out_reg.pc + out_reg.imm) : (out_reg.pc + XLEN'(4));
   assign misaligned = taken && (target[1:0] != 2'b00);
   assign redirect   = out_reg.is_branch && (taken != out_reg.pred_taken) && !misaligned;

   // Everything is forced to zero while empty so reset and flush leave clean outputs.
   assign bus.o_valid      = out_valid_reg;
   assign bus.o_result     = (out_valid_reg && !out_reg.is_branch) ? {{(XLEN-1){1'b0}}, cond} : '0;
   assign bus.o_taken      = out_valid_reg && taken;
   assign bus.o_target     = out_valid_reg ? target : '0;
   assign bus.o_misaligned = out_valid_reg && misaligned;
   assign bus.o_redirect   = out_valid_reg && redirect;

   // A delivery in a flush cycle still counts: flush only kills held entries.
   always_comb begin
      cnt_next = cnt_reg;
      if (out_fire && redirect && !(&cnt_reg)) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   assign o_mispredict_cnt = cnt_reg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         out_valid_reg  <= 1'b0;
         skid_valid_reg <= 1'b0;
         out_reg        <= '0;
         skid_reg       <= '0;
         cnt_reg        <= '0;
      end else begin
         out_valid_reg  <= out_valid_next;
         skid_valid_reg <= skid_valid_next;
         out_reg        <= out_next;
         skid_reg       <= skid_next;
         cnt_reg        <= cnt_next;
      end
   end

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed bench for branch_resolve_stage: occupancy-queue reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_branch_resolve_stage;
   import branch_resolve_pkg::*;

   localparam int XLEN  = 32;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [CNT_W-1:0] cnt;

   branch_resolve_stage_if #(.XLEN(XLEN)) bus();

   branch_resolve_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .bus              (bus),
      .o_mispredict_cnt (cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      rv32_compop  op;
      bit          br;
      logic [31:0] rs1, rs2, pc, imm;
      bit          pred;
   } entry_t;

   typedef struct {
      logic [31:0] result;
      bit          taken;
      logic [31:0] target;
      bit          redirect;
      bit          mis;
   } exp_t;

   int          vectors     = 0;
   int          miscompares = 0;
   entry_t      mq[$];
   logic [31:0] delivered[$];
   int          mcnt  = 0;
   bit          armed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t predict(input entry_t e);
      exp_t x;
      bit   c;
      case (e.op)
         compop_eq:  c = (e.rs1 == e.rs2);
         compop_ne:  c = (e.rs1 != e.rs2);
         compop_lts: c = ($signed(e.rs1) <  $signed(e.rs2));
         compop_ltu: c = (e.rs1 <  e.rs2);
         compop_ges: c = ($signed(e.rs1) >= $signed(e.rs2));
         compop_geu: c = (e.rs1 >= e.rs2);
         default:    c = 0;
      endcase
      if (e.br) begin
         x.result   = 0;
         x.taken    = c;
         x.target   = c ? e.pc + e.imm : e.pc + 32'd4;
         x.mis      = c && (x.target % 4 != 0);
         x.redirect = (c != e.pred) && !x.mis;
      end else begin
         x.result   = {31'd0, c};
         x.taken    = 0;
         x.target   = e.pc + 32'd4;
         x.mis      = 0;
         x.redirect = 0;
      end
      return x;
   endfunction

   // Model: the stage is a FIFO of at most two entries; the head is what is shown.
   always @(negedge clk) begin
      exp_t   ex;
      entry_t cur;
      bit     out_x, in_acc;
      if (rst) begin
         mq.delete();
         mcnt  = 0;
         armed = 1;
      end else if (armed) begin
         chk("o_valid", 32'(bus.o_valid), 32'(mq.size() > 0));
         chk("o_ready", 32'(bus.o_ready), 32'(mq.size() < 2));
         chk("mispredict_cnt", 32'(cnt), 32'(mcnt));
         if (mq.size() > 0) begin
            ex = predict(mq[0]);
            chk("o_result", bus.o_result, ex.result);
            chk("o_taken", 32'(bus.o_taken), 32'(ex.taken));
            chk("o_target", bus.o_target, ex.target);
            chk("o_redirect", 32'(bus.o_redirect), 32'(ex.redirect));
            chk("o_misaligned", 32'(bus.o_misaligned), 32'(ex.mis));
         end
         if (bus.o_valid && bus.i_ready) delivered.push_back(bus.o_target);
         out_x = (mq.size() > 0) && bus.i_ready;
         if (out_x) begin
            ex = predict(mq[0]);
            if (ex.redirect && mcnt < (1 << CNT_W) - 1) mcnt++;
         end
         if (bus.i_flush) begin
            mq.delete();
         end else begin
            in_acc = bus.i_valid && (mq.size() < 2);
            if (out_x) void'(mq.pop_front());
            if (in_acc) begin
               cur.op = bus.i_compop;   cur.br  = bus.i_is_branch;
               cur.rs1 = bus.i_rs1;     cur.rs2 = bus.i_rs2;
               cur.pc = bus.i_pc;       cur.imm = bus.i_imm;
               cur.pred = bus.i_pred_taken;
               mq.push_back(cur);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input rv32_compop op, input bit br, input logic [31:0] a, b, pc, imm,
                         input bit pred);
      bus.i_valid = 1'b1;  bus.i_compop = op;  bus.i_is_branch = br;
      bus.i_rs1 = a;  bus.i_rs2 = b;  bus.i_pc = pc;  bus.i_imm = imm;
      bus.i_pred_taken = pred;
   endtask

   task automatic wait_accept();
      bit acc = 0;
      int n = 0;
      while (!acc && n < 20) begin
         @(negedge clk);
         acc = bus.o_ready;
         step();
         n++;
      end
      bus.i_valid = 1'b0;
      chk("accept_within_bound", 32'(acc), 32'd1);
   endtask

   task automatic send(input rv32_compop op, input bit br, input logic [31:0] a, b, pc, imm,
                       input bit pred);
      set_in(op, br, a, b, pc, imm, pred);
      wait_accept();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rpat, vpat;
      logic [31:0] sat_exp [5];
      sat_exp = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};
      rst = 1'b1;
      bus.i_valid = 0; bus.i_compop = compop_nop; bus.i_is_branch = 0;
      bus.i_rs1 = 0; bus.i_rs2 = 0; bus.i_pc = 0; bus.i_imm = 0; bus.i_pred_taken = 0;
      bus.i_ready = 1; bus.i_flush = 0;
      repeat (2) step();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_o_valid", 32'(bus.o_valid), 0);
      chk("rst_o_ready", 32'(bus.o_ready), 1);
      chk("rst_o_target", bus.o_target, 0);
      chk("rst_o_result", bus.o_result, 0);
      chk("rst_cnt", 32'(cnt), 0);
      step();

      // BEQ taken, predicted not taken -> redirect
      send(compop_eq, 1, 32'h5, 32'h5, 32'h100, 32'h20, 0);
      @(negedge clk);
      chk("beq_valid", 32'(bus.o_valid), 1);
      chk("beq_taken", 32'(bus.o_taken), 1);
      chk("beq_target", bus.o_target, 32'h120);
      chk("beq_redirect", 32'(bus.o_redirect), 1);
      step();
      @(negedge clk);
      chk("beq_cnt", 32'(cnt), 1);
      step();

      // Signedness on 0xFFFFFFFF vs 1
      send(compop_lts, 1, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h40, 1);
      @(negedge clk);
      chk("blt_taken", 32'(bus.o_taken), 1);
      chk("blt_target", bus.o_target, 32'h140);
      step();
      send(compop_ltu, 1, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h40, 1);
      @(negedge clk);
      chk("bltu_taken", 32'(bus.o_taken), 0);
      chk("bltu_target", bus.o_target, 32'h104);
      step();
      send(compop_ltu, 0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h0, 0);
      @(negedge clk);
      chk("sltu_result", bus.o_result, 0);
      step();
      send(compop_lts, 0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h0, 0);
      @(negedge clk);
      chk("slt_result", bus.o_result, 1);
      step();

      // Backpressure: A held, B skidded, C stalled
      delivered.delete();
      bus.i_ready = 0;
      set_in(compop_eq, 1, 1, 2, 32'h200, 32'h10, 0); step();
      set_in(compop_eq, 1, 1, 2, 32'h300, 32'h10, 0); step();
      set_in(compop_eq, 1, 1, 2, 32'h400, 32'h10, 0);
      @(negedge clk);
      chk("bp_ready_low", 32'(bus.o_ready), 0);
      chk("bp_hold_a", bus.o_target, 32'h204);
      step();
      @(negedge clk);
      chk("bp_still_a", bus.o_target, 32'h204);
      step();
      bus.i_ready = 1;
      wait_accept();
      repeat (3) step();
      chk("bp_count", 32'(delivered.size()), 3);
      if (delivered.size() == 3) begin
         chk("bp_order0", delivered[0], 32'h204);
         chk("bp_order1", delivered[1], 32'h304);
         chk("bp_order2", delivered[2], 32'h404);
      end

      // Misaligned taken branch: no redirect, counter stays at 2
      send(compop_ne, 1, 1, 2, 32'h100, 32'h2, 0);
      @(negedge clk);
      chk("mis_target", bus.o_target, 32'h102);
      chk("mis_flag", 32'(bus.o_misaligned), 1);
      chk("mis_redirect", 32'(bus.o_redirect), 0);
      step();
      @(negedge clk);
      chk("mis_cnt", 32'(cnt), 2);
      step();

      // Flush with both slots full plus a new input
      delivered.delete();
      bus.i_ready = 0;
      set_in(compop_eq, 1, 3, 3, 32'h500, 32'h10, 0); step();
      set_in(compop_eq, 1, 3, 3, 32'h510, 32'h10, 0); step();
      set_in(compop_eq, 1, 3, 3, 32'h520, 32'h10, 0);
      bus.i_flush = 1; step();
      bus.i_flush = 0; bus.i_valid = 0;
      @(negedge clk);
      chk("flush_valid", 32'(bus.o_valid), 0);
      chk("flush_ready", 32'(bus.o_ready), 1);
      step();
      bus.i_ready = 1;
      set_in(compop_eq, 1, 3, 3, 32'h530, 32'h10, 0);
      bus.i_flush = 1; step();
      bus.i_flush = 0; bus.i_valid = 0;
      repeat (3) step();
      chk("flush_none_out", 32'(delivered.size()), 0);

      // Delivery in a flush cycle still counts (2 -> 3)
      send(compop_eq, 1, 4, 4, 32'h540, 32'h10, 0);
      bus.i_flush = 1; step();
      bus.i_flush = 0;
      @(negedge clk);
      chk("flush_xfer_cnt", 32'(cnt), 3);
      step();

      // Back-to-back stream with no bubble
      delivered.delete();
      for (int i = 0; i < 4; i++) begin
         set_in(compop_ltu, 0, 32'(i), 32'd2, 32'h600 + 32'(16 * i), 0, 0);
         step();
      end
      bus.i_valid = 0;
      repeat (2) step();
      chk("stream_count", 32'(delivered.size()), 4);

      // Mixed valid/ready pattern swept against the model
      rpat = 32'hB6D5_3A9C;
      vpat = 32'hF7BE_DF6D;
      for (int i = 0; i < 32; i++) begin
         bus.i_ready = rpat[i];
         bus.i_valid = vpat[i];
         bus.i_compop = rv32_compop'(i % 7);
         bus.i_is_branch = (i % 3) != 0;
         bus.i_rs1 = 32'(i) * 32'h1357_9BDF;
         bus.i_rs2 = 32'(i) * 32'h0246_8ACE;
         bus.i_pc = 32'h1000 + 32'(4 * i);
         bus.i_imm = (i % 4 == 1) ? 32'h2 : 32'hFFFF_FFF0;
         bus.i_pred_taken = (i % 5) < 2;
         step();
      end
      bus.i_valid = 0;
      bus.i_ready = 1;
      repeat (3) step();

      // Reset mid-transfer with both slots occupied
      bus.i_ready = 0;
      send(compop_eq, 1, 1, 1, 32'h800, 32'h8, 0);
      send(compop_eq, 1, 1, 1, 32'h900, 32'h8, 0);
      rst = 1; repeat (2) step();
      rst = 0; bus.i_ready = 1;
      @(negedge clk);
      chk("rst_mid_valid", 32'(bus.o_valid), 0);
      chk("rst_mid_cnt", 32'(cnt), 0);
      step();

      // Counter saturation at CNT_W=2
      for (int k = 0; k < 5; k++) begin
         send(compop_eq, 1, 7, 7, 32'h700, 32'h8, 0);
         step();
         @(negedge clk);
         chk($sformatf("sat_cnt%0d", k), 32'(cnt), sat_exp[k]);
         step();
      end
      rst = 1; repeat (2) step();
      rst = 0;
      @(negedge clk);
      chk("sat_rst_cnt", 32'(cnt), 0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
